// File: rtl/chrono_display_scan.sv
// chrono_display_scan: scans the four chronometer BCD digits onto a multiplexed,
// common-anode 7-segment display. The digits are snapshotted once per frame,
// leading zeros above the decimal point are blanked, and a sticky flag records
// any non-BCD digit that reaches the decoder.
module chrono_display_scan #(
  parameter int SCAN_PERIOD   = 50000,
  parameter bit BLANK_LEADING = 1'b1,
  parameter int DP_DIGIT      = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] bcd_in,
  input  logic        freeze_in,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  an_out,
  output logic        err_out
);

  localparam int PW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_PERIOD - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          err_q, err_d;

  logic          presc_tc;
  logic [3:0]    digit;
  logic [3:0]    zero_from;
  logic          blank;
  logic [6:0]    seg_dec;

  // Prescaler, slot counter and per-frame snapshot of the incoming digits
  always_comb begin
    presc_tc = (presc_q == PRESC_LAST);
    presc_d  = presc_tc ? '0 : presc_q + 1'b1;
    slot_d   = presc_tc ? slot_q + 2'd1 : slot_q;
    snap_d   = snap_q;
    // Frame boundary is the wrap of slot 3 back to slot 0
    if (presc_tc && (slot_q == 2'd3) && !freeze_in) begin
      snap_d = bcd_in;
    end
  end

  // Digit selection, leading-zero blanking and 7-segment decode
  always_comb begin
    digit = snap_q[{slot_q, 2'b00} +: 4];
    // zero_from[k]: digits k..3 of the snapshot are all zero
    zero_from = {snap_q[15:12] == 4'd0, snap_q[15:8] == 8'd0,
                 snap_q[15:4] == 12'd0, snap_q == 16'd0};
    blank = BLANK_LEADING && (int'(slot_q) > DP_DIGIT) && zero_from[slot_q];
    case (digit)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end

  // Next output values; the first cycle of each slot keeps all anodes off
  always_comb begin
    seg_d = blank ? 7'h7F : seg_dec;
    an_d  = (presc_q == '0) ? 4'hF : ~(4'b0001 << slot_q);
    dp_d  = !((int'(slot_q) == DP_DIGIT) && (presc_q != '0));
    err_d = err_q | (digit > 4'd9);
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_q <= '0;
      slot_q  <= 2'd0;
      snap_q  <= 16'h0000;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= 4'hF;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      err_q   <= err_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign an_out  = an_q;
  assign err_out = err_q;

endmodule

// File: tb/tb_chrono_display_scan.sv
// Testbench for chrono_display_scan with a cycle-count based reference model.
module tb_chrono_display_scan;

  localparam int SP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = 16'h1234;
  logic        freeze = 1'b0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, err_a, err_b;
  logic [3:0]  an_a, an_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chrono_display_scan #(.SCAN_PERIOD(SP), .BLANK_LEADING(1'b1), .DP_DIGIT(2)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .bcd_in(bcd), .freeze_in(freeze),
    .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a), .err_out(err_a));

  chrono_display_scan #(.SCAN_PERIOD(SP), .BLANK_LEADING(1'b0), .DP_DIGIT(2)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .bcd_in(bcd), .freeze_in(freeze),
    .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b), .err_out(err_b));

  // Reference model: time since reset determines slot/prescaler arithmetically;
  // the expected outputs after an edge come from the state before that edge.
  logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int          cyc;
  logic [15:0] m_snap;
  logic [6:0]  e_seg, e_seg_nb;
  logic        e_dp, e_err;
  logic [3:0]  e_an;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_snap = 16'h0; e_seg = 7'h7F; e_seg_nb = 7'h7F;
      e_dp = 1'b1; e_an = 4'hF; e_err = 1'b0;
    end else begin
      int p, s, v;
      logic [6:0] raw;
      p = cyc % SP;
      s = (cyc / SP) % 4;
      v = (m_snap >> (4 * s)) & 16'hF;
      raw = (v > 9) ? 7'h3F : seg_tab[v];
      e_seg_nb = raw;
      e_seg = (s > 2 && (m_snap >> (4 * s)) == 0) ? 7'h7F : raw;
      e_an = (p == 0) ? 4'hF : 4'hF & ~(4'b0001 << s);
      e_dp = !(s == 2 && p != 0);
      if (v > 9) e_err = 1'b1;
      if (p == SP - 1 && s == 3 && !freeze) m_snap = bcd;
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("an", {12'h0, an_a}, {12'h0, e_an});
    chk("seg", {9'h0, seg_a}, {9'h0, e_seg});
    chk("dp", {15'h0, dp_a}, {15'h0, e_dp});
    chk("err", {15'h0, err_a}, {15'h0, e_err});
    chk("seg_noblank", {9'h0, seg_b}, {9'h0, e_seg_nb});
    chk("an_noblank", {12'h0, an_b}, {12'h0, e_an});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    int found;
    // Held in reset
    repeat (3) @(negedge clk);
    chk("rst_an", {12'h0, an_a}, 16'hF);
    chk("rst_seg", {9'h0, seg_a}, 16'h7F);
    chk("rst_dp", {15'h0, dp_a}, 16'h1);
    chk("rst_err", {15'h0, err_a}, 16'h0);
    rst_n = 1'b1;
    // Frame 1 shows the reset snapshot, then 1234
    step(3 * 4 * SP);
    // Leading zero blanking with the point on d2
    bcd = 16'h0507;
    step(2 * 4 * SP);
    // Freeze mid-frame while the input keeps moving
    bcd = 16'h0912;
    step(4 * SP + 5);
    freeze = 1'b1;
    for (int i = 0; i < 3 * 4 * SP; i++) begin
      bcd = rand_bcd();
      step(1);
    end
    freeze = 1'b0;
    step(2 * 4 * SP);
    chk("err_clear_pre", {15'h0, err_a}, 16'h0);
    // Non-BCD digit sets the sticky error flag
    bcd = 16'h00A0;
    step(2 * 4 * SP);
    chk("err_set", {15'h0, err_a}, 16'h1);
    bcd = 16'h0000;
    step(2 * 4 * SP);
    chk("err_sticky", {15'h0, err_a}, 16'h1);
    chk("err_sticky_b", {15'h0, err_b}, 16'h1);
    // Randomised traffic including occasional non-BCD values and freeze toggles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) bcd = ($urandom_range(0, 9) == 0) ? 16'($urandom) : rand_bcd();
      if ($urandom_range(0, 19) == 0) freeze = ~freeze;
      step(1);
    end
    freeze = 1'b0;
    // Reset in the middle of slot 2
    found = 0;
    for (int i = 0; i < 8 * 4 * SP; i++) begin
      if (((cyc / SP) % 4) == 2 && (cyc % SP) == 2) begin
        found = 1;
        break;
      end
      step(1);
    end
    chk("find_slot2", 16'(found), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_an", {12'h0, an_a}, 16'hF);
    chk("midrst_seg", {9'h0, seg_a}, 16'h7F);
    chk("midrst_dp", {15'h0, dp_a}, 16'h1);
    chk("midrst_err", {15'h0, err_a}, 16'h0);
    bcd = 16'h4321;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("restart_guard", {12'h0, an_a}, 16'hF);
    step(1);
    chk("restart_slot0", {12'h0, an_a}, 16'hE);
    step(3 * 4 * SP);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
